// File: rtl/divider_datapath_pkg.sv
// Shared ALU constants for the control unit and the datapaths:
// default operand width and the iteration counter width derived from it.
package divider_datapath_pkg;

  localparam int ALU_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int ALU_CNT_W = cnt_width(ALU_WIDTH);

endpackage

// File: rtl/divider_datapath_reg.sv
// Plain parameterised state register; reset and hold are folded into d
// by the owner, so this is a bare D flop bank.
module divider_datapath_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    q <= d;
  end

endmodule

// File: rtl/divider_datapath.sv
// Non-restoring unsigned divider datapath. The external control unit drives
// one step enable per cycle; illegal enable mixes do nothing but raise a sticky error.
module divider_datapath
  import divider_datapath_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             divider_load,
  input  logic             divider_shift_en,
  input  logic             divider_add_en,
  input  logic             divider_sub_en,
  input  logic             divider_count_en,
  input  logic             divider_final_add,
  output logic             divider_sign_R,
  output logic             divider_counter_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             protocol_err
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH:0]   r_d, r_q;
  logic [WIDTH-1:0] q_d, q_q;
  logic [WIDTH-1:0] dreg_d, dreg_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             sign_d, sign_q;
  logic             dbz_d, dbz_q;
  logic             perr_d, perr_q;

  logic             op_en;
  logic             illegal;
  logic             do_sub;
  logic [WIDTH:0]   addsub_b;
  logic [WIDTH:0]   addsub_sum;

  assign op_en   = divider_add_en | divider_sub_en;
  // Both arith enables at once, or any two distinct step kinds together.
  assign illegal = (divider_add_en & divider_sub_en)
                 | (divider_shift_en & (op_en | divider_count_en | divider_final_add))
                 | (op_en & (divider_count_en | divider_final_add))
                 | (divider_count_en & divider_final_add);

  // Single adder/subtractor shared by add, sub and the final correction.
  assign do_sub     = divider_sub_en & ~divider_add_en;
  assign addsub_b   = do_sub ? ~{1'b0, dreg_q} : {1'b0, dreg_q};
  assign addsub_sum = r_q + addsub_b + (WIDTH + 1)'(do_sub);

  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    dreg_d = dreg_q;
    cnt_d  = cnt_q;
    sign_d = sign_q;
    dbz_d  = dbz_q;
    perr_d = perr_q;
    if (reset) begin
      r_d    = '0;
      q_d    = '0;
      dreg_d = '0;
      cnt_d  = '0;
      sign_d = 1'b0;
      dbz_d  = 1'b0;
      perr_d = 1'b0;
    end else if (divider_load) begin
      r_d    = '0;
      q_d    = dividend;
      dreg_d = divisor;
      cnt_d  = '0;
      sign_d = 1'b0;
      dbz_d  = (divisor == '0);
      perr_d = 1'b0;
    end else if (illegal) begin
      perr_d = 1'b1;
    end else begin
      if (divider_shift_en) begin
        sign_d = r_q[WIDTH];
        r_d    = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_d    = {q_q[WIDTH-2:0], 1'b0};
      end
      if (op_en) begin
        r_d = addsub_sum;
        q_d = {q_q[WIDTH-1:1], ~addsub_sum[WIDTH]};
      end
      if (divider_count_en && (cnt_q != CW'(WIDTH))) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (divider_final_add && r_q[WIDTH]) begin
        r_d = addsub_sum;
      end
    end
  end

  divider_datapath_reg #(.W(WIDTH + 1)) u_r_reg    (.clk(clk), .d(r_d),    .q(r_q));
  divider_datapath_reg #(.W(WIDTH))     u_q_reg    (.clk(clk), .d(q_d),    .q(q_q));
  divider_datapath_reg #(.W(WIDTH))     u_d_reg    (.clk(clk), .d(dreg_d), .q(dreg_q));
  divider_datapath_reg #(.W(CW))        u_cnt_reg  (.clk(clk), .d(cnt_d),  .q(cnt_q));
  divider_datapath_reg #(.W(1))         u_sign_reg (.clk(clk), .d(sign_d), .q(sign_q));
  divider_datapath_reg #(.W(1))         u_dbz_reg  (.clk(clk), .d(dbz_d),  .q(dbz_q));
  divider_datapath_reg #(.W(1))         u_perr_reg (.clk(clk), .d(perr_d), .q(perr_q));

  assign divider_sign_R       = sign_q;
  assign divider_counter_done = (cnt_q == CW'(WIDTH));
  assign quotient             = q_q;
  assign remainder            = r_q[WIDTH-1:0];
  assign div_by_zero          = dbz_q;
  assign protocol_err         = perr_q;

endmodule

// File: doc/divider_datapath.md
DIVIDER_DATAPATH -- requirements
Module: divider_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port dividend, input, WIDTH, unsigned dividend, sampled on load.
REQ-005 SHALL have port divisor, input, WIDTH, unsigned divisor, sampled on load.
REQ-006 SHALL have port divider_load, input, 1, load operands and clear iteration state.
REQ-007 SHALL have port divider_shift_en, input, 1, shift {R,Q} left by one bit.
REQ-008 SHALL have port divider_add_en, input, 1, R <= R + D.
REQ-009 SHALL have port divider_sub_en, input, 1, R <= R - D.
REQ-010 SHALL have port divider_count_en, input, 1, increment the iteration counter.
REQ-011 SHALL have port divider_final_add, input, 1, remainder correction step.
REQ-012 SHALL have port divider_sign_R, output, 1, the sign of R captured before the last shift; it steers add/sub.
REQ-013 SHALL have port divider_counter_done, output, 1, high when the counter equals WIDTH.
REQ-014 SHALL have port quotient, output, WIDTH, the Q register.
REQ-015 SHALL have port remainder, output, WIDTH, R[WIDTH-1:0].
REQ-016 SHALL have port div_by_zero, output, 1, set on load when divisor == 0.
REQ-017 SHALL have port protocol_err, output, 1, sticky flag for illegal enable combinations.

Function
REQ-018 SHALL implement non-restoring unsigned division with registers R (WIDTH+1 bits, two's complement), Q (WIDTH), D (WIDTH), cnt (clog2(WIDTH)+1 bits) and sign_flag (1).
REQ-019 SHALL, on load: R<=0, Q<=dividend, D<=divisor, cnt<=0, sign_flag<=0, div_by_zero<=(divisor==0), protocol_err<=0.
REQ-020 SHALL, on shift: sign_flag<=R[WIDTH] (pre-shift value); {R,Q}<={R,Q}<<1, with Q[0] left at 0.
REQ-021 SHALL, on add or sub: update R modulo 2^(WIDTH+1), then set Q[0]<=~Rnew[WIDTH].
REQ-022 SHALL drive divider_sign_R = sign_flag, registered with no combinational path from enables.
REQ-023 SHALL, on count: increment cnt, saturating at WIDTH; divider_counter_done=(cnt==WIDTH), combinational from cnt.
REQ-024 SHALL, on final_add: if R[WIDTH]==1 then R<=R+D; otherwise R is unchanged; Q is unchanged.
REQ-025 SHALL give precedence reset > load > all other enables; load with other enables asserted acts as load only.
REQ-026 SHALL, when add and sub are asserted together: update neither R nor Q, and set protocol_err<=1.
REQ-027 SHALL, when two of {shift, add/sub, count, final_add} are asserted together: apply none, set protocol_err<=1.
REQ-028 SHALL hold all registers when no enable is asserted.
REQ-029 SHALL, with divisor==0, complete the sequence normally: quotient=all ones, remainder=dividend.
REQ-030 SHALL support one-cycle latency per step: each result is visible the cycle after its enable.

Reset
REQ-031 SHALL set on reset: R, Q, D, cnt, sign_flag, div_by_zero and protocol_err to 0, so every output reads 0.
REQ-032 SHALL abandon any in-progress division on reset; a following load starts cleanly.

Structure
REQ-033 SHALL take WIDTH and the counter width from the shared ALU constants package, used by the control unit and all datapaths.
REQ-034 SHALL store all state in instances of the codebase's parameterised register sub-module, with reset muxed into d.
REQ-035 SHALL contain a single (WIDTH+1)-bit adder/subtractor shared by add, sub and final_add.

Verification
REQ-036 SHALL cover 100/7 with the full sequence load, 8x(shift, op by sign, count), final_add -> quotient=14, remainder=2, done=1.
REQ-037 SHALL cover 255/1 -> quotient=255, remainder=0; and 5/10 -> quotient=0, remainder=5.
REQ-038 SHALL cover 37/0 -> div_by_zero=1 after load, quotient=0xFF, remainder=37.
REQ-039 SHALL cover reset asserted after the 4th iteration of 200/3 -> all outputs 0 next cycle; reload 200/3 -> quotient=66, remainder=2.
REQ-040 SHALL cover add and sub asserted together -> R and Q unchanged, protocol_err=1, held until next load or reset.
